// File: rtl/leds_pattern_gen_pkg.sv
// leds_pkg: shared types for the LED pattern generator.
// No ports: mode codes, colour one-hots, level type, pin indices.
package leds_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_FLASH  = 2'b01,
    MODE_BOUNCE = 2'b10
  } mode_e;

  localparam int LVL_W = 2;
  typedef logic [LVL_W-1:0] lvl_t;
  localparam lvl_t LVL_MIN = 2'd0;
  localparam lvl_t LVL_MAX = 2'd3;

  typedef logic [2:0] col_t;
  localparam col_t COL_R = 3'b001;
  localparam col_t COL_G = 3'b010;
  localparam col_t COL_B = 3'b100;

  localparam int BTN_MODE = 0;
  localparam int BTN_COL  = 1;
  localparam int BTN_UP   = 2;
  localparam int BTN_DN   = 3;

  localparam int SW_RUN = 0;
  localparam int SW_DIR = 3;

  function automatic mode_e mode_next(
    input mode_e m
  );
    mode_e n;
    case (m)
      MODE_SHIFT:  n = MODE_FLASH;
      MODE_FLASH:  n = MODE_BOUNCE;
      default:     n = MODE_SHIFT;
    endcase
    return n;
  endfunction

  function automatic col_t col_next(
    input col_t c
  );
    return {c[1:0], c[2]};
  endfunction

endpackage

// File: rtl/leds_pattern_gen_if.sv
// leds_pattern_gen_if: board-side bundle of switches, buttons, LEDs.
// Ports: i_sw, i_btn (toward core); o_led, o_led_r/g/b (from core).
interface leds_pattern_gen_if #(
  parameter int N_LEDS = 4,
  parameter int NB_SW  = 4,
  parameter int NB_BTN = 4
);

  logic [NB_SW-1:0]  i_sw;
  logic [NB_BTN-1:0] i_btn;
  logic [N_LEDS-1:0] o_led;
  logic [N_LEDS-1:0] o_led_r;
  logic [N_LEDS-1:0] o_led_g;
  logic [N_LEDS-1:0] o_led_b;

  modport master (
    output i_sw,
    output i_btn,
    input  o_led,
    input  o_led_r,
    input  o_led_g,
    input  o_led_b
  );

  modport slave (
    input  i_sw,
    input  i_btn,
    output o_led,
    output o_led_r,
    output o_led_g,
    output o_led_b
  );

endinterface

// File: rtl/leds_pattern_gen_btn_sync_edge.sv
// btn_sync_edge: 2-flop synchroniser plus rising-edge pulse per bit.
// Ports: clk, rst_n (async low), i_d raw pins, o_rise 1-cycle pulses.
module btn_sync_edge #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // r_s3 only remembers last level, so a held button fires once
  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/leds_pattern_gen.sv
// leds_pattern_gen: rotate/flash/bounce RGB LED driver with PWM dim.
// Ports: CLK100MHZ, ck_rst (async low), bus (slave: sw, btn, leds).
module leds_pattern_gen
  import leds_pkg::*;
#(
  parameter int N_LEDS     = 4,
  parameter int NB_COUNTER = 32,
  parameter int BASE_SHIFT = 22,
  parameter int NB_PWM     = 8,
  parameter int NB_SW      = 4,
  parameter int NB_BTN     = 4
) (
  input logic               CLK100MHZ,
  input logic               ck_rst,
  leds_pattern_gen_if.slave bus
);

  localparam logic [NB_COUNTER-1:0] CNT_ONE =
    NB_COUNTER'(1);
  localparam logic [N_LEDS-1:0] PAT_ONE =
    N_LEDS'(1);
  localparam logic [N_LEDS-1:0] STAT_RST =
    N_LEDS'(4'b1100);

  // switch synchroniser
  logic [NB_SW-1:0] r_sw_m;
  logic [NB_SW-1:0] r_sw;

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      r_sw_m <= '0;
      r_sw   <= '0;
    end else begin
      r_sw_m <= bus.i_sw;
      r_sw   <= r_sw_m;
    end
  end

  // button edges
  logic [NB_BTN-1:0] w_rise;

  btn_sync_edge #(
    .W (NB_BTN)
  ) u_btn (
    .clk    (CLK100MHZ),
    .rst_n  (ck_rst),
    .i_d    (bus.i_btn),
    .o_rise (w_rise)
  );

  // lowest index wins; losers are dropped
  logic [NB_BTN-1:0] w_act;

  always_comb begin
    w_act = '0;
    if (w_rise[BTN_MODE])
      w_act[BTN_MODE] = 1'b1;
    else if (w_rise[BTN_COL])
      w_act[BTN_COL] = 1'b1;
    else if (w_rise[BTN_UP])
      w_act[BTN_UP] = 1'b1;
    else if (w_rise[BTN_DN])
      w_act[BTN_DN] = 1'b1;
  end

  // rate counter
  logic [NB_COUNTER-1:0] r_cnt;
  logic [NB_COUNTER-1:0] w_lim;
  logic                  w_tick;

  always_comb begin
    w_lim = (CNT_ONE << (BASE_SHIFT + int'(r_sw[2:1])))
          - CNT_ONE;
  end

  // >= so a rate drop below the count ticks at once
  assign w_tick = r_sw[SW_RUN] & (r_cnt >= w_lim);

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst)
      r_cnt <= '0;
    else if (w_tick)
      r_cnt <= '0;
    else if (r_sw[SW_RUN])
      r_cnt <= r_cnt + CNT_ONE;
  end

  // pattern next-state on tick
  mode_e             r_mode;
  logic [N_LEDS-1:0] r_pat;
  logic              r_dir_up;
  col_t              r_col;
  lvl_t              r_lvl;
  logic [N_LEDS-1:0] w_pat_nxt;
  logic              w_dir_nxt;

  always_comb begin
    w_pat_nxt = r_pat;
    w_dir_nxt = r_dir_up;
    unique case (r_mode)
      MODE_SHIFT: begin
        if (r_sw[SW_DIR])
          w_pat_nxt = {r_pat[N_LEDS-2:0],
                       r_pat[N_LEDS-1]};
        else
          w_pat_nxt = {r_pat[0],
                       r_pat[N_LEDS-1:1]};
      end
      MODE_FLASH: begin
        w_pat_nxt = ~r_pat;
      end
      MODE_BOUNCE: begin
        if (r_dir_up) begin
          if (r_pat[N_LEDS-1]) begin
            w_pat_nxt = r_pat >> 1;
            w_dir_nxt = 1'b0;
          end else begin
            w_pat_nxt = r_pat << 1;
          end
        end else begin
          if (r_pat[0]) begin
            w_pat_nxt = r_pat << 1;
            w_dir_nxt = 1'b1;
          end else begin
            w_pat_nxt = r_pat >> 1;
          end
        end
      end
      default: ;
    endcase
  end

  // mode FSM with pattern, colour and level
  mode_e w_mode_nxt;
  assign w_mode_nxt = mode_next(r_mode);

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      r_mode   <= MODE_SHIFT;
      r_pat    <= PAT_ONE;
      r_dir_up <= 1'b1;
      r_col    <= COL_R;
      r_lvl    <= LVL_MAX;
    end else begin
      unique case (1'b1)
        w_act[BTN_MODE]: begin
          r_mode   <= w_mode_nxt;
          r_dir_up <= 1'b1;
          if (w_mode_nxt == MODE_FLASH)
            r_pat <= '1;
          else
            r_pat <= PAT_ONE;
        end
        w_act[BTN_COL]: begin
          r_col <= col_next(r_col);
        end
        w_act[BTN_UP]: begin
          if (r_lvl != LVL_MAX)
            r_lvl <= r_lvl + lvl_t'(1);
        end
        w_act[BTN_DN]: begin
          if (r_lvl != LVL_MIN)
            r_lvl <= r_lvl - lvl_t'(1);
        end
        default: ;
      endcase
      // a mode change swallows a coincident tick
      if (w_tick && !w_act[BTN_MODE]) begin
        r_pat    <= w_pat_nxt;
        r_dir_up <= w_dir_nxt;
      end
    end
  end

  // PWM
  logic [NB_PWM-1:0] r_pwm;
  logic [NB_PWM:0]   w_thr;
  logic              w_pwm_on;

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst)
      r_pwm <= '0;
    else
      r_pwm <= r_pwm + NB_PWM'(1);
  end

  // extra bit lets level 3 reach full scale
  always_comb begin
    w_thr = ((NB_PWM+1)'(r_lvl) + (NB_PWM+1)'(1))
          << (NB_PWM-2);
  end

  assign w_pwm_on = {1'b0, r_pwm} < w_thr;

  // output registers
  logic [N_LEDS-1:0] w_lit;
  logic [N_LEDS-1:0] w_stat;
  logic [N_LEDS-1:0] r_led;
  logic [N_LEDS-1:0] r_led_r;
  logic [N_LEDS-1:0] r_led_g;
  logic [N_LEDS-1:0] r_led_b;

  assign w_lit = r_pat & {N_LEDS{w_pwm_on}};

  always_comb begin
    w_stat      = '0;
    w_stat[3:0] = {r_lvl, r_mode};
  end

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      r_led   <= STAT_RST;
      r_led_r <= '0;
      r_led_g <= '0;
      r_led_b <= '0;
    end else begin
      r_led   <= w_stat;
      r_led_r <= (r_col == COL_R) ? w_lit : '0;
      r_led_g <= (r_col == COL_G) ? w_lit : '0;
      r_led_b <= (r_col == COL_B) ? w_lit : '0;
    end
  end

  assign bus.o_led   = r_led;
  assign bus.o_led_r = r_led_r;
  assign bus.o_led_g = r_led_g;
  assign bus.o_led_b = r_led_b;

endmodule

// File: tb/tb_leds_pattern_gen.sv
// tb_leds_pattern_gen: directed vectors for leds_pattern_gen.
// Small config: N=4, BASE_SHIFT=2, NB_COUNTER=8, NB_PWM=8.
module tb_leds_pattern_gen;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  leds_pattern_gen_if #(
    .N_LEDS (N),
    .NB_SW  (4),
    .NB_BTN (4)
  ) bus ();

  leds_pattern_gen #(
    .N_LEDS     (N),
    .NB_COUNTER (8),
    .BASE_SHIFT (2),
    .NB_PWM     (8),
    .NB_SW      (4),
    .NB_BTN     (4)
  ) dut (
    .CLK100MHZ (clk),
    .ck_rst    (rst_n),
    .bus       (bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic [3:0] led;
  } vec_t;

  vec_t tv[8];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic wait_change(
    output int         n,
    output logic [3:0] v
  );
    logic [11:0] prev;
    prev = {bus.o_led_r, bus.o_led_g, bus.o_led_b};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ({bus.o_led_r, bus.o_led_g, bus.o_led_b}
               == prev && n < 300);
    chk("wait_bound", 32'(n < 300), 1);
    v = bus.o_led_r | bus.o_led_g | bus.o_led_b;
  endtask

  task automatic press(
    input logic [3:0] b,
    input int         hold
  );
    bus.i_btn = b;
    repeat (hold) @(negedge clk);
    bus.i_btn = 4'b0000;
    repeat (6) @(negedge clk);
  endtask

  task automatic count_on(output int c);
    c = 0;
    repeat (256) begin
      @(negedge clk);
      if (bus.o_led_g != 4'b0000) c++;
    end
  endtask

  function automatic logic [3:0] ror(
    input logic [3:0] p
  );
    return {p[0], p[3:1]};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n;
    int c;
    logic [3:0] v;
    logic [3:0] prev;
    logic [3:0] bseq[7];

    tv[0] = '{1,  4'b0001, 4'b0, 4'b0, 4'b1100};
    tv[1] = '{6,  4'b0001, 4'b0, 4'b0, 4'b1100};
    tv[2] = '{7,  4'b0010, 4'b0, 4'b0, 4'b1100};
    tv[3] = '{10, 4'b0010, 4'b0, 4'b0, 4'b1100};
    tv[4] = '{11, 4'b0100, 4'b0, 4'b0, 4'b1100};
    tv[5] = '{15, 4'b1000, 4'b0, 4'b0, 4'b1100};
    tv[6] = '{18, 4'b1000, 4'b0, 4'b0, 4'b1100};
    tv[7] = '{19, 4'b0001, 4'b0, 4'b0, 4'b1100};

    bseq[0] = 4'b0010;
    bseq[1] = 4'b0100;
    bseq[2] = 4'b1000;
    bseq[3] = 4'b0100;
    bseq[4] = 4'b0010;
    bseq[5] = 4'b0001;
    bseq[6] = 4'b0010;

    bus.i_sw  = 4'b1001;
    bus.i_btn = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_r", 32'(bus.o_led_r), 0);
    chk("rst_g", 32'(bus.o_led_g), 0);
    chk("rst_b", 32'(bus.o_led_b), 0);
    chk("rst_led", 32'(bus.o_led), 32'hC);
    rst_n = 1'b1;

    // rotate toward MSB, period 4
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      while (cyc < tv[i].cyc) begin
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("vec%0d_r", i),
          32'(bus.o_led_r), 32'(tv[i].r));
      chk($sformatf("vec%0d_g", i),
          32'(bus.o_led_g), 32'(tv[i].g));
      chk($sformatf("vec%0d_b", i),
          32'(bus.o_led_b), 32'(tv[i].b));
      chk($sformatf("vec%0d_led", i),
          32'(bus.o_led), 32'(tv[i].led));
    end
    while (cyc < 22) begin
      @(negedge clk);
      cyc++;
    end

    // rate 3, toward LSB, period 32
    bus.i_sw = 4'b0111;
    wait_change(n, v);
    chk("last_fast_val", 32'(v), 32'h2);
    prev = v;
    wait_change(n, v);
    chk("slow_period", n, 32);
    chk("slow_val", 32'(v), 32'(ror(prev)));
    prev = v;
    wait_change(n, v);
    chk("slow_period2", n, 32);
    chk("slow_val2", 32'(v), 32'(ror(prev)));
    prev = v;

    // pause holds the count
    repeat (10) @(negedge clk);
    bus.i_sw = 4'b0110;
    repeat (40) @(negedge clk);
    chk("frozen", 32'(bus.o_led_r), 32'(prev));
    bus.i_sw = 4'b0111;
    wait_change(n, v);
    chk("resume_rest", n, 22);
    chk("resume_val", 32'(v), 32'(ror(prev)));
    prev = v;

    // rate drop below count
    repeat (20) @(negedge clk);
    bus.i_sw = 4'b0001;
    wait_change(n, v);
    chk("rate_drop_lat", n, 4);
    chk("rate_drop_val", 32'(v), 32'(ror(prev)));

    // FLASH then BOUNCE with run stopped
    bus.i_sw = 4'b0000;
    repeat (4) @(negedge clk);
    press(4'b0001, 3);
    chk("flash_r", 32'(bus.o_led_r), 32'hF);
    chk("flash_led", 32'(bus.o_led), 32'hD);
    press(4'b0001, 3);
    chk("bounce_r", 32'(bus.o_led_r), 32'h1);
    chk("bounce_led", 32'(bus.o_led), 32'hE);
    bus.i_sw = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      wait_change(n, v);
      chk($sformatf("bounce%0d", i),
          32'(v), 32'(bseq[i]));
    end
    bus.i_sw = 4'b0000;
    repeat (4) @(negedge clk);
    press(4'b0001, 3);
    chk("shift_again_r", 32'(bus.o_led_r), 32'h1);
    chk("shift_again_led", 32'(bus.o_led), 32'hC);

    // held colour button acts once
    press(4'b0010, 20);
    chk("green_g", 32'(bus.o_led_g), 32'h1);
    chk("green_r", 32'(bus.o_led_r), 0);
    chk("green_b", 32'(bus.o_led_b), 0);

    // btn0+btn1: only mode moves
    press(4'b0011, 3);
    chk("both_g", 32'(bus.o_led_g), 32'hF);
    chk("both_r", 32'(bus.o_led_r), 0);
    chk("both_b", 32'(bus.o_led_b), 0);
    chk("both_led", 32'(bus.o_led), 32'hD);

    // brightness saturates both ways
    repeat (4) press(4'b1000, 3);
    chk("dim_led", 32'(bus.o_led), 32'h1);
    count_on(c);
    chk("dim_duty", c, 64);
    repeat (5) press(4'b0100, 3);
    chk("bright_led", 32'(bus.o_led), 32'hD);
    count_on(c);
    chk("bright_duty", c, 256);

    // async reset with a tick pending
    bus.i_sw = 4'b0001;
    repeat (4) @(negedge clk);
    wait_change(n, v);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_r", 32'(bus.o_led_r), 0);
    chk("arst_g", 32'(bus.o_led_g), 0);
    chk("arst_b", 32'(bus.o_led_b), 0);
    chk("arst_led", 32'(bus.o_led), 32'hC);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_r", 32'(bus.o_led_r), 32'h1);
    chk("post_g", 32'(bus.o_led_g), 0);
    chk("post_led", 32'(bus.o_led), 32'hC);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
